// File: rtl/colour_conversion_pkg.sv
// Shared types and fixed-point constants for the YUV->RGB pipe.
package colour_conversion_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_Y,
        S_RD_U,
        S_RD_V,
        S_WAIT,
        S_CALC,
        S_WR0,
        S_WR1,
        S_WR2,
        S_DONE
    } state_t;

    // Which plane register a returning read word belongs to.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_Y,
        TAG_U,
        TAG_V
    } tag_t;

    localparam int Q_SHIFT = 16;
    localparam logic signed [31:0] Q_ROUND   = 32'sd32768;
    localparam logic signed [31:0] UV_OFFSET = 32'sd128;

    // BT.601 studio range
    localparam logic signed [31:0] STUDIO_YOFF = 32'sd16;
    localparam logic signed [31:0] STUDIO_CY   = 32'sd76284;
    localparam logic signed [31:0] STUDIO_CRV  = 32'sd104595;
    localparam logic signed [31:0] STUDIO_CGU  = -32'sd25624;
    localparam logic signed [31:0] STUDIO_CGV  = -32'sd53281;
    localparam logic signed [31:0] STUDIO_CBU  = 32'sd132251;

    // Full range
    localparam logic signed [31:0] FULL_YOFF = 32'sd0;
    localparam logic signed [31:0] FULL_CY   = 32'sd65536;
    localparam logic signed [31:0] FULL_CRV  = 32'sd91881;
    localparam logic signed [31:0] FULL_CGU  = -32'sd22554;
    localparam logic signed [31:0] FULL_CGV  = -32'sd46802;
    localparam logic signed [31:0] FULL_CBU  = 32'sd116130;

    function automatic logic [7:0] clip_u8(input logic signed [31:0] x);
        if (x < 0)
            return 8'd0;
        else if (x > 32'sd255)
            return 8'd255;
        else
            return x[7:0];
    endfunction

endpackage

// File: rtl/colour_conversion_pipe_if.sv
// Word-memory bus of the colour conversion pipe: one read port, one write port.
interface colour_conversion_pipe_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] R_addr;
    logic [15:0]       R_data;
    logic [ADDR_W-1:0] W_addr;
    logic [15:0]       W_data;
    logic              Wrenb;

    modport master (
        output R_addr,
        input  R_data,
        output W_addr,
        output W_data,
        output Wrenb
    );

    modport slave (
        input  R_addr,
        output R_data,
        input  W_addr,
        input  W_data,
        input  Wrenb
    );
endinterface

// File: rtl/colour_conversion_pixel_calc.sv
// Combinational single-pixel YUV->RGB conversion in Q16 with clipping to 0..255.
module colour_conversion_pixel_calc
    import colour_conversion_pkg::*;
(
    input  logic [7:0] y,
    input  logic [7:0] u,
    input  logic [7:0] v,
    input  logic       mode,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);
    logic signed [31:0] yoff, cy, crv, cgu, cgv, cbu;
    logic signed [31:0] ys, us, vs;
    logic signed [31:0] racc, gacc, bacc;

    // Coefficient select, offset removal, fixed-point sums and clipping.
    always_comb begin
        if (mode) begin
            yoff = FULL_YOFF;
            cy   = FULL_CY;
            crv  = FULL_CRV;
            cgu  = FULL_CGU;
            cgv  = FULL_CGV;
            cbu  = FULL_CBU;
        end else begin
            yoff = STUDIO_YOFF;
            cy   = STUDIO_CY;
            crv  = STUDIO_CRV;
            cgu  = STUDIO_CGU;
            cgv  = STUDIO_CGV;
            cbu  = STUDIO_CBU;
        end
        ys   = $signed({24'd0, y}) - yoff;
        us   = $signed({24'd0, u}) - UV_OFFSET;
        vs   = $signed({24'd0, v}) - UV_OFFSET;
        racc = (cy * ys + crv * vs + Q_ROUND) >>> Q_SHIFT;
        gacc = (cy * ys + cgu * us + cgv * vs + Q_ROUND) >>> Q_SHIFT;
        bacc = (cy * ys + cbu * us + Q_ROUND) >>> Q_SHIFT;
        r    = clip_u8(racc);
        g    = clip_u8(gacc);
        b    = clip_u8(bacc);
    end
endmodule

// File: rtl/colour_conversion_pipe.sv
// Frame-sequenced YUV->RGB converter: reads Y/U/V words per pixel pair, writes 3 packed RGB words.
module colour_conversion_pipe
    import colour_conversion_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int PIXEL_COUNT = 76800,
    parameter int Y_BASE      = 0,
    parameter int U_BASE      = 38400,
    parameter int V_BASE      = 76800,
    parameter int RGB_BASE    = 115200,
    parameter int RD_LAT      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     mode,
    colour_conversion_pipe_if.master bus,
    output logic                     busy,
    output logic                     done
);
    localparam int NPAIR = PIXEL_COUNT / 2;
    localparam int K_W   = (NPAIR > 1) ? $clog2(NPAIR) : 1;

    localparam logic [K_W-1:0]    K_LAST     = K_W'(NPAIR - 1);
    localparam logic [2:0]        WAIT_LAST  = 3'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] Y_BASE_A   = ADDR_W'(Y_BASE);
    localparam logic [ADDR_W-1:0] U_BASE_A   = ADDR_W'(U_BASE);
    localparam logic [ADDR_W-1:0] V_BASE_A   = ADDR_W'(V_BASE);
    localparam logic [ADDR_W-1:0] RGB_BASE_A = ADDR_W'(RGB_BASE);

    state_t            state, state_n;
    logic [K_W-1:0]    k, k_n;
    logic [2:0]        wcnt;
    logic              mode_q;
    tag_t              tag_cur;
    tag_t              tags [RD_LAT];
    logic [15:0]       y_q, u_q, v_q;
    logic [7:0]        r0, g0, b0, r1, g1, b1;
    logic [7:0]        b0_q, r1_q, g1_q, b1_q;
    logic [ADDR_W-1:0] k_a, wbase;
    logic [ADDR_W-1:0] raddr_n, waddr_n;
    logic [15:0]       wdata_n;
    logic              wren_n, busy_n, done_n;

    colour_conversion_pixel_calc even_px (
        .y(y_q[15:8]), .u(u_q[15:8]), .v(v_q[15:8]), .mode(mode_q),
        .r(r0), .g(g0), .b(b0)
    );

    colour_conversion_pixel_calc odd_px (
        .y(y_q[7:0]), .u(u_q[7:0]), .v(v_q[7:0]), .mode(mode_q),
        .r(r1), .g(g1), .b(b1)
    );

    // Next state and pair counter.
    always_comb begin
        state_n = state;
        k_n     = k;
        if (clear) begin
            state_n = S_IDLE;
            k_n     = '0;
        end else begin
            case (state)
                S_IDLE: if (start) state_n = S_RD_Y;
                S_RD_Y: state_n = S_RD_U;
                S_RD_U: state_n = S_RD_V;
                S_RD_V: state_n = S_WAIT;
                S_WAIT: if (wcnt == WAIT_LAST) state_n = S_CALC;
                S_CALC: state_n = S_WR0;
                S_WR0:  state_n = S_WR1;
                S_WR1:  state_n = S_WR2;
                S_WR2: begin
                    if (k == K_LAST) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_RD_Y;
                        k_n     = k + 1'b1;
                    end
                end
                S_DONE: begin
                    state_n = S_IDLE;
                    k_n     = '0;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Registered outputs are computed from the next state so they line up with it.
    // R0/G0 go straight from the calculators into W_data on the CALC edge.
    always_comb begin
        k_a     = ADDR_W'(k_n);
        wbase   = RGB_BASE_A + k_a + k_a + k_a;
        raddr_n = bus.R_addr;
        waddr_n = bus.W_addr;
        wdata_n = bus.W_data;
        wren_n  = 1'b0;
        case (state_n)
            S_RD_Y: raddr_n = Y_BASE_A + k_a;
            S_RD_U: raddr_n = U_BASE_A + k_a;
            S_RD_V: raddr_n = V_BASE_A + k_a;
            S_WR0: begin
                wren_n  = 1'b1;
                waddr_n = wbase;
                wdata_n = {r0, g0};
            end
            S_WR1: begin
                wren_n  = 1'b1;
                waddr_n = wbase + ADDR_W'(1);
                wdata_n = {b0_q, r1_q};
            end
            S_WR2: begin
                wren_n  = 1'b1;
                waddr_n = wbase + ADDR_W'(2);
                wdata_n = {g1_q, b1_q};
            end
            default: ;
        endcase
        busy_n = !(state_n == S_IDLE || state_n == S_DONE);
        done_n = (state_n == S_DONE);
    end

    // Tag of the read word issued this cycle.
    always_comb begin
        tag_cur = TAG_NONE;
        case (state)
            S_RD_Y:  tag_cur = TAG_Y;
            S_RD_U:  tag_cur = TAG_U;
            S_RD_V:  tag_cur = TAG_V;
            default: ;
        endcase
    end

    // FSM state, counters, mode register and bus outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            k          <= '0;
            wcnt       <= '0;
            mode_q     <= 1'b0;
            bus.R_addr <= '0;
            bus.W_addr <= '0;
            bus.W_data <= '0;
            bus.Wrenb  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            k          <= k_n;
            wcnt       <= (state == S_WAIT && state_n == S_WAIT) ? wcnt + 3'd1 : '0;
            if (state == S_IDLE && start && !clear)
                mode_q <= mode;
            bus.R_addr <= raddr_n;
            bus.W_addr <= waddr_n;
            bus.W_data <= wdata_n;
            bus.Wrenb  <= wren_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // Latency tag pipeline, plane capture and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < RD_LAT; i++)
                tags[i] <= TAG_NONE;
            y_q  <= '0;
            u_q  <= '0;
            v_q  <= '0;
            b0_q <= '0;
            r1_q <= '0;
            g1_q <= '0;
            b1_q <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < RD_LAT; i++)
                tags[i] <= TAG_NONE;
        end else begin
            tags[0] <= tag_cur;
            for (int unsigned i = 1; i < RD_LAT; i++)
                tags[i] <= tags[i-1];
            case (tags[RD_LAT-1])
                TAG_Y:   y_q <= bus.R_data;
                TAG_U:   u_q <= bus.R_data;
                TAG_V:   v_q <= bus.R_data;
                default: ;
            endcase
            if (state == S_CALC) begin
                b0_q <= b0;
                r1_q <= r1;
                g1_q <= g1;
                b1_q <= b1;
            end
        end
    end
endmodule

// File: tb/tb_colour_conversion_pipe.sv
// Scoreboard bench: two pipes (single pair / latency 1, four pairs / latency 3 with address wrap).
module tb_colour_conversion_pipe;
    localparam int AW    = 18;
    localparam int MASK  = (1 << AW) - 1;
    localparam int Y_B   = 0;
    localparam int U_B   = 16;
    localparam int V_B   = 32;
    localparam int RGB0  = 48;
    localparam int RGB1  = (1 << AW) - 4;
    localparam int LAT0  = 1;
    localparam int LAT1  = 3;
    localparam int PC0   = 2;
    localparam int PC1   = 8;

    typedef struct {
        int          inst;
        int unsigned a;
        logic [15:0] d;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst [2];
    logic          clear [2];
    logic          start [2];
    logic          mode [2];
    logic          busy [2];
    logic          done [2];
    logic [AW-1:0] raddr [2];
    logic [AW-1:0] waddr [2];
    logic [15:0]   wdata [2];
    logic          wren [2];
    logic [15:0]   mem [2][64];

    wr_t sb [$];
    int  wr0_cyc [$];
    int  ndone [2];
    int  last_done [2];
    int  n_chk = 0;
    int  n_pass = 0;

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int LAT = (g == 0) ? LAT0 : LAT1;
        colour_conversion_pipe_if #(.ADDR_W(AW)) bus ();
        logic [15:0] rpipe [LAT];

        colour_conversion_pipe #(
            .ADDR_W(AW),
            .PIXEL_COUNT((g == 0) ? PC0 : PC1),
            .Y_BASE(Y_B),
            .U_BASE(U_B),
            .V_BASE(V_B),
            .RGB_BASE((g == 0) ? RGB0 : RGB1),
            .RD_LAT(LAT)
        ) dut (
            .clk(clk),
            .rst(rst[g]),
            .clear(clear[g]),
            .start(start[g]),
            .mode(mode[g]),
            .bus(bus.master),
            .busy(busy[g]),
            .done(done[g])
        );

        always @(posedge clk) begin
            rpipe[0] <= mem[g][bus.R_addr[5:0]];
            for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        end
        assign bus.R_data = rpipe[LAT-1];
        assign raddr[g] = bus.R_addr;
        assign waddr[g] = bus.W_addr;
        assign wdata[g] = bus.W_data;
        assign wren[g]  = bus.Wrenb;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] clip(input int x);
        if (x < 0) return 8'd0;
        if (x > 255) return 8'd255;
        return x[7:0];
    endfunction

    task automatic px(input logic [7:0] yb, ub, vb, input logic m,
                      output logic [7:0] r, g, b);
        int yo, cy, crv, cgu, cgv, cbu, y, u, v;
        if (m) begin
            yo = 0;  cy = 65536; crv = 91881;  cgu = -22554; cgv = -46802; cbu = 116130;
        end else begin
            yo = 16; cy = 76284; crv = 104595; cgu = -25624; cgv = -53281; cbu = 132251;
        end
        y = int'({24'd0, yb}) - yo;
        u = int'({24'd0, ub}) - 128;
        v = int'({24'd0, vb}) - 128;
        r = clip((cy * y + crv * v + 32768) >>> 16);
        g = clip((cy * y + cgu * u + cgv * v + 32768) >>> 16);
        b = clip((cy * y + cbu * u + 32768) >>> 16);
    endtask

    task automatic push_word(input int g, input int addr, input logic [15:0] d);
        wr_t w;
        w.inst = g;
        w.a    = int'(addr & MASK);
        w.d    = d;
        sb.push_back(w);
    endtask

    // Expected writes of a frame, truncated to the first nwords.
    task automatic push_frame(input int g, input logic m, input int nwords);
        logic [7:0] r0, g0, b0, r1, g1, b1;
        logic [15:0] yw, uw, vw;
        int base, npair, n;
        base  = (g == 0) ? RGB0 : RGB1;
        npair = ((g == 0) ? PC0 : PC1) / 2;
        n = 0;
        for (int k = 0; k < npair; k++) begin
            yw = mem[g][Y_B + k];
            uw = mem[g][U_B + k];
            vw = mem[g][V_B + k];
            px(yw[15:8], uw[15:8], vw[15:8], m, r0, g0, b0);
            px(yw[7:0], uw[7:0], vw[7:0], m, r1, g1, b1);
            if (n < nwords) push_word(g, base + 3 * k, {r0, g0});
            n++;
            if (n < nwords) push_word(g, base + 3 * k + 1, {b0, r1});
            n++;
            if (n < nwords) push_word(g, base + 3 * k + 2, {g1, b1});
            n++;
        end
    endtask

    task automatic load(input int g, input int k, input logic [15:0] y, u, v);
        mem[g][Y_B + k] = y;
        mem[g][U_B + k] = u;
        mem[g][V_B + k] = v;
    endtask

    task automatic check_idle(input int g, input string tag);
        check({tag, "_raddr"}, 32'(raddr[g]), 0);
        check({tag, "_waddr"}, 32'(waddr[g]), 0);
        check({tag, "_wdata"}, 32'(wdata[g]), 0);
        check({tag, "_wren"},  32'(wren[g]), 0);
        check({tag, "_busy"},  32'(busy[g]), 0);
        check({tag, "_done"},  32'(done[g]), 0);
    endtask

    // Pulses start; mode is flipped once busy to show it is not re-sampled.
    task automatic start_frame(input int g, input logic m, output int cs);
        @(negedge clk);
        start[g] = 1'b1;
        mode[g]  = m;
        cs = cyc;
        @(negedge clk);
        start[g] = 1'b0;
        mode[g]  = ~m;
        #1;
        check("busy_after_start", 32'(busy[g]), 1);
    endtask

    task automatic wait_done(input int g, input int d0, input int budget, input string tag);
        int n = 0;
        while (ndone[g] == d0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (ndone[g] == d0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic finish_frame(input int g, input int d0, input int cs, input int exp_lat, input string tag);
        wait_done(g, d0, 300, tag);
        check({tag, "_done_cycle"}, 32'(last_done[g] - cs), 32'(exp_lat));
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_done_count"}, 32'(ndone[g] - d0), 1);
        check({tag, "_sb_empty"}, 32'(sb.size()), 0);
    endtask

    task automatic run_frame(input int g, input logic m, input int exp_lat, input string tag);
        int cs, d0;
        d0 = ndone[g];
        start_frame(g, m, cs);
        finish_frame(g, d0, cs, exp_lat, tag);
    endtask

    // Write monitor: pops the scoreboard on every write, counts done pulses.
    wr_t mon_w;
    int  mon_off;
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (wren[g] === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'(waddr[g]), 32'hFFFF_FFFF);
                end else begin
                    mon_w = sb.pop_front();
                    check("wr_inst", 32'(g), 32'(mon_w.inst));
                    check("wr_addr", 32'(waddr[g]), mon_w.a);
                    check("wr_data", 32'(wdata[g]), 32'(mon_w.d));
                end
                mon_off = (int'(waddr[g]) - ((g == 0) ? RGB0 : RGB1) + (1 << AW)) & MASK;
                if (g == 1 && mon_off % 3 == 0) wr0_cyc.push_back(cyc);
            end
            if (done[g] === 1'b1) begin
                ndone[g]++;
                last_done[g] = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs, d0;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b0; clear[g] = 1'b0; start[g] = 1'b0; mode[g] = 1'b0;
            ndone[g] = 0; last_done[g] = 0;
            for (int a = 0; a < 64; a++) mem[g][a] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        #1;
        check_idle(0, "reset0");
        check_idle(1, "reset1");
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        repeat (2) @(negedge clk);

        // 1: studio black/white pair, single pair frame
        load(0, 0, 16'h10EB, 16'h8080, 16'h8080);
        push_word(0, RGB0,     16'h0000);
        push_word(0, RGB0 + 1, 16'h00FF);
        push_word(0, RGB0 + 2, 16'hFFFF);
        run_frame(0, 1'b0, 8 + LAT0, "t1");

        // 2: full range grey, mode flipped while busy
        load(0, 0, 16'hC8C8, 16'h8080, 16'h8080);
        push_word(0, RGB0,     16'hC8C8);
        push_word(0, RGB0 + 1, 16'hC8C8);
        push_word(0, RGB0 + 2, 16'hC8C8);
        run_frame(0, 1'b1, 8 + LAT0, "t2");

        // 3: clipping in studio range
        load(0, 0, 16'hFF00, 16'h8080, 16'hFFFF);
        push_frame(0, 1'b0, 3);
        run_frame(0, 1'b0, 8 + LAT0, "t3");

        // 6a: start held through the first busy cycles is ignored
        load(0, 0, 16'h5A90, 16'h3CC4, 16'hA070);
        push_frame(0, 1'b0, 3);
        d0 = ndone[0];
        @(negedge clk);
        start[0] = 1'b1;
        mode[0]  = 1'b0;
        cs = cyc;
        repeat (4) @(negedge clk);
        start[0] = 1'b0;
        finish_frame(0, d0, cs, 8 + LAT0, "t6a");

        // 6b: reset in WAIT drops the pair, outputs return to zero
        d0 = ndone[0];
        start_frame(0, 1'b1, cs);
        repeat (3) @(negedge clk);
        #1;
        check("t6_wait_busy", 32'(busy[0]), 1);
        check("t6_wait_raddr", 32'(raddr[0]), V_B);
        rst[0] = 1'b0;
        #1;
        check_idle(0, "t6_rst");
        repeat (2) @(negedge clk);
        rst[0] = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check_idle(0, "t6_post");
        check("t6_no_done", 32'(ndone[0] - d0), 0);

        // 6c: fresh frame after reset, full range
        push_frame(0, 1'b1, 3);
        run_frame(0, 1'b1, 8 + LAT0, "t6c");

        // 4: four pairs, latency 3, write addresses wrap past the top of memory
        for (int k = 0; k < PC1 / 2; k++)
            load(1, k, 16'($urandom), 16'($urandom), 16'($urandom));
        push_frame(1, 1'b0, 12);
        wr0_cyc.delete();
        run_frame(1, 1'b0, 4 * (7 + LAT1) + 1, "t4");
        check("t4_wr0_count", 32'(wr0_cyc.size()), 4);
        for (int i = 1; i < 4; i++)
            if (i < wr0_cyc.size())
                check("t4_pair_period", 32'(wr0_cyc[i] - wr0_cyc[i-1]), 7 + LAT1);

        // 5: clear during WR1 of the second pair, then a clean restart
        for (int k = 0; k < PC1 / 2; k++)
            load(1, k, 16'($urandom), 16'($urandom), 16'($urandom));
        push_frame(1, 1'b0, 5);
        d0 = ndone[1];
        start_frame(1, 1'b0, cs);
        begin
            int n = 0;
            while (!(wren[1] === 1'b1 && 32'(waddr[1]) == ((RGB1 + 4) & MASK)) && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (n >= 100) check("t5_wr1_timeout", 0, 1);
        end
        clear[1] = 1'b1;
        @(negedge clk);
        #1;
        clear[1] = 1'b0;
        check("t5_wren_after_clear", 32'(wren[1]), 0);
        check("t5_busy_after_clear", 32'(busy[1]), 0);
        repeat (40) @(negedge clk);
        #1;
        check("t5_no_done", 32'(ndone[1] - d0), 0);
        check("t5_sb_empty", 32'(sb.size()), 0);
        push_frame(1, 1'b1, 12);
        run_frame(1, 1'b1, 4 * (7 + LAT1) + 1, "t5r");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
